mod_arith_seq: RTL and testbench

//  Sequencer for the ECC modular-arithmetic U datapath (U register + A/B operand regs).

---
 rtl/mod_arith_pkg.sv | 47 ++++
 rtl/mod_arith_seq_if.sv | 56 +++++
 rtl/mod_arith_seq_cnt.sv | 47 ++++
 rtl/mod_arith_seq.sv | 187 ++++++++++++++++++
 tb/tb_mod_arith_seq.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-arithmetic U-datapath sequencer:
// U-register op encodings, sequencer state encoding, modulus select values,
// the latched command payload and the per-step iteration increment helper.
package mod_arith_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned PERF_W = 16;
    localparam int unsigned INC_W  = 2;

    // U register operation issued alongside u_en
    typedef enum logic [OP_W-1:0] {
        OP_U_SETV  = 2'b00,
        OP_U_MHLV  = 2'b01,
        OP_U_MQRTR = 2'b10,
        OP_U_CLEAR = 2'b11
    } u_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_ITER = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } seq_state_e;

    // Modulus select: field prime or group order
    typedef enum logic {
        MP0 = 1'b0,
        MP1 = 1'b1
    } mod_sel_e;

    // Command attributes latched at start acceptance
    typedef struct packed {
        logic     mul;
        mod_sel_e modp;
    } cmd_t;

    // A mod 4 pattern that allows only a single halving step
    localparam logic [1:0] A_BIN_HALF = 2'b10;

    // Bit positions consumed by one ITER step
    function automatic logic [INC_W-1:0] step_inc(input u_op_e op);
        return (op == OP_U_MHLV) ? INC_W'(1) : INC_W'(2);
    endfunction

endpackage

// File: rtl/mod_arith_seq_if.sv
// Command / datapath-control bundle between the ECC control FSM, the
// sequencer and the mod_arith datapath.
//   master : command source side (start, mode, mod_sel, abort) plus the
//            datapath status (dp_stall, a_bin, a_zero); observes results.
//   slave  : the sequencer; drives u_op/u_en/ab_en, flags, busy, done,
//            err, iter_cnt (and perf_cyc when MOD_ARITH_SEQ_PERF_EN is set).
interface mod_arith_seq_if #(
    parameter int unsigned CNT_W = 10
);
    import mod_arith_pkg::*;

    logic             start;
    logic             mode;
    logic             mod_sel;
    logic             abort;
    logic             dp_stall;
    logic [1:0]       a_bin;
    logic             a_zero;

    u_op_e            u_op;
    logic             u_en;
    logic             ab_en;
    logic             flg_mod;
    logic             flg_mul;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;

`ifdef MOD_ARITH_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_cyc;

    modport master (
        output start, mode, mod_sel, abort, dp_stall, a_bin, a_zero,
        input  u_op, u_en, ab_en, flg_mod, flg_mul, busy, done, err, iter_cnt,
               perf_cyc
    );

    modport slave (
        input  start, mode, mod_sel, abort, dp_stall, a_bin, a_zero,
        output u_op, u_en, ab_en, flg_mod, flg_mul, busy, done, err, iter_cnt,
               perf_cyc
    );
`else
    modport master (
        output start, mode, mod_sel, abort, dp_stall, a_bin, a_zero,
        input  u_op, u_en, ab_en, flg_mod, flg_mul, busy, done, err, iter_cnt
    );

    modport slave (
        input  start, mode, mod_sel, abort, dp_stall, a_bin, a_zero,
        output u_op, u_en, ab_en, flg_mod, flg_mul, busy, done, err, iter_cnt
    );
`endif

endinterface

// File: rtl/mod_arith_seq_cnt.sv
// Saturating up-counter used for the iteration count and the busy-cycle
// performance count.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (wins over en)
//   en, inc  : add inc when en is high, saturating at all-ones
//   cnt      : registered count
module mod_arith_seq_cnt #(
    parameter int unsigned W     = 10,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     cnt
);

    localparam int unsigned SUM_W = W + 1;
    localparam logic [W:0]  SAT   = {1'b0, {W{1'b1}}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum;

    // One extra bit on the sum detects overflow before it can wrap
    always_comb begin
        sum   = {1'b0, cnt_q} + SUM_W'(inc);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (sum > SAT) ? SAT[W-1:0] : sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mod_arith_seq.sv
// Sequencer for the ECC modular-arithmetic U datapath. Accepts one command
// at a time and steps CLEAR -> SETV -> halving/quartering loop until A is
// zero (done), the iteration budget runs out (err) or the command is aborted.
// All outputs are registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mod_arith_seq_if.slave (command, datapath status, U/A/B
//              controls, flags, busy/done/err, iter_cnt)
// Optional build macro MOD_ARITH_SEQ_PERF_EN adds bus.perf_cyc, the busy
// cycle count of the last command (stalls included, saturating).
module mod_arith_seq
    import mod_arith_pkg::*;
#(
    parameter int unsigned ITER_MAX = 512,
    parameter int unsigned CNT_W    = 10
) (
    input  logic           clk,
    input  logic           rst,
    mod_arith_seq_if.slave bus
);

    seq_state_e        state_q, state_d;
    u_op_e             u_op_q, u_op_d;
    logic              u_en_q, u_en_d;
    logic              ab_en_q, ab_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    cmd_t              cmd_q, cmd_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [INC_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  iter_cnt;
    u_op_e             step_op;

    // Step selection from the low bits of A
    always_comb begin
        if (bus.a_bin == A_BIN_HALF) begin
            step_op = OP_U_MHLV;
        end else begin
            step_op = OP_U_MQRTR;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        u_op_d  = u_op_q;
        u_en_d  = 1'b0;
        ab_en_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cmd_d   = cmd_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        cnt_inc = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    cmd_d.mul  = bus.mode;
                    cmd_d.modp = mod_sel_e'(bus.mod_sel);
                    cnt_clr    = 1'b1;
                    state_d    = ST_CLR;
                    u_op_d     = OP_U_CLEAR;
                    u_en_d     = 1'b1;
                end
            end

            ST_CLR: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!bus.dp_stall) begin
                    state_d = ST_LOAD;
                    u_op_d  = OP_U_SETV;
                    u_en_d  = 1'b1;
                    ab_en_d = 1'b1;
                end
            end

            ST_LOAD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!bus.dp_stall) begin
                    state_d = ST_ITER;
                end
            end

            // a_zero beats the budget check, which beats stepping
            ST_ITER: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!bus.dp_stall) begin
                    if (bus.a_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (iter_cnt >= CNT_W'(ITER_MAX)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        u_op_d  = step_op;
                        u_en_d  = 1'b1;
                        ab_en_d = 1'b1;
                        cnt_en  = 1'b1;
                        cnt_inc = step_inc(step_op);
                    end
                end
            end

            // Terminal pulses are never held by a stall
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            u_op_q  <= OP_U_CLEAR;
            u_en_q  <= 1'b0;
            ab_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            u_op_q  <= u_op_d;
            u_en_q  <= u_en_d;
            ab_en_q <= ab_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cmd_q   <= cmd_d;
        end
    end

    // Bit positions consumed in the current command
    mod_arith_seq_cnt #(
        .W     (CNT_W),
        .INC_W (INC_W)
    ) u_iter_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .inc (cnt_inc),
        .cnt (iter_cnt)
    );

`ifdef MOD_ARITH_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_cyc;

    // Counts every cycle busy is high; stops once the command leaves busy
    mod_arith_seq_cnt #(
        .W     (PERF_W),
        .INC_W (INC_W)
    ) u_perf_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (busy_q),
        .inc (INC_W'(1)),
        .cnt (perf_cyc)
    );

    assign bus.perf_cyc = perf_cyc;
`endif

    assign bus.u_op     = u_op_q;
    assign bus.u_en     = u_en_q;
    assign bus.ab_en    = ab_en_q;
    assign bus.flg_mod  = cmd_q.modp;
    assign bus.flg_mul  = cmd_q.mul;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.iter_cnt = iter_cnt;

endmodule

// File: tb/tb_mod_arith_seq.sv
// Bench for mod_arith_seq: plays the A-register datapath, compares each
// command against a spec-level model (op list, final count, done/err,
// busy length), plus directed reset, stall, abort and busy-start sequences.
module tb_mod_arith_seq;
    import mod_arith_pkg::*;

    localparam int unsigned ITER_MAX = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned BUDGET   = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mod_arith_seq_if #(.CNT_W(CNT_W)) bus ();

    mod_arith_seq #(.ITER_MAX(ITER_MAX), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Model results
    logic [1:0]  exp_ops[$];
    int unsigned exp_steps, exp_cnt;
    bit          exp_done;

    // Observed results
    logic [1:0]  obs_ops[$];
    int unsigned obs_busy, obs_stalls, obs_done, obs_err, obs_cnt;
    int unsigned obs_ab_bad, obs_end_edge, obs_fmod, obs_fmul, obs_perf;
    bit          obs_timeout;
    int unsigned a_val;

    typedef struct {
        int unsigned a0;
        bit          mode;
        bit          ms;
        int unsigned steps;
        int unsigned cnt;
        bit          done;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a();
        bus.a_bin  = 2'(a_val);
        bus.a_zero = (a_val == 0);
    endtask

    // Spec-level model: halve on A%4==2, otherwise quarter; stop on A==0 or budget
    function automatic void model(input int unsigned a0);
        int unsigned a = a0;
        exp_ops.delete();
        exp_ops.push_back(2'b11);
        exp_ops.push_back(2'b00);
        exp_steps = 0;
        exp_cnt   = 0;
        while (1) begin
            if (a == 0) begin
                exp_done = 1'b1;
                break;
            end
            if (exp_cnt >= ITER_MAX) begin
                exp_done = 1'b0;
                break;
            end
            if (a % 4 == 2) begin
                exp_ops.push_back(2'b01);
                a = a / 2;
                exp_cnt += 1;
            end else begin
                exp_ops.push_back(2'b10);
                a = a / 4;
                exp_cnt += 2;
            end
            exp_steps++;
        end
    endfunction

    function automatic int unsigned ops_diff();
        int unsigned d = 0;
        if (obs_ops.size() != exp_ops.size()) d++;
        for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++)
            if (obs_ops[i] !== exp_ops[i]) d++;
        return d;
    endfunction

    // Issue one command and act as the A-register datapath until busy drops
    task automatic run_cmd(input int unsigned a0, input bit md, input bit ms,
                           input int unsigned stall_pct, input int unsigned n_steps);
        bit ended = 1'b0;
        int steps_seen;
        obs_ops.delete();
        obs_busy = 0; obs_stalls = 0; obs_done = 0; obs_err = 0; obs_cnt = 0;
        obs_ab_bad = 0; obs_end_edge = 0; obs_fmod = 0; obs_fmul = 0; obs_perf = 0;
        obs_timeout = 1'b0;
        a_val = a0;
        drive_a();
        bus.mode     = md;
        bus.mod_sel  = ms;
        bus.start    = 1'b1;
        bus.dp_stall = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            if (bus.busy) obs_busy++;
            if (bus.u_en) begin
                obs_ops.push_back(bus.u_op);
                if (bus.ab_en !== (bus.u_op != OP_U_CLEAR)) obs_ab_bad++;
                if (bus.ab_en) begin
                    case (bus.u_op)
                        OP_U_SETV:  a_val = a0;
                        OP_U_MHLV:  a_val = a_val / 2;
                        OP_U_MQRTR: a_val = a_val / 4;
                        default:    ;
                    endcase
                end
            end else if (bus.ab_en) begin
                obs_ab_bad++;
            end
            if (bus.done) obs_done++;
            if (bus.err) obs_err++;
            if (bus.done || bus.err) begin
                obs_cnt      = 32'(bus.iter_cnt);
                obs_end_edge = k;
                obs_fmod     = 32'(bus.flg_mod);
                obs_fmul     = 32'(bus.flg_mul);
            end
            if (!bus.busy) begin
                ended = 1'b1;
                break;
            end
            drive_a();
            steps_seen   = int'(obs_ops.size()) - 2;
            bus.dp_stall = (steps_seen < int'(n_steps)) && ($urandom_range(99) < stall_pct);
            if (bus.dp_stall) obs_stalls++;
            tick();
        end
        bus.dp_stall = 1'b0;
`ifdef MOD_ARITH_SEQ_PERF_EN
        obs_perf = 32'(bus.perf_cyc);
`endif
        obs_timeout = !ended;
    endtask

    task automatic check_cmd(input bit ms, input bit md);
        chk("ops", ops_diff(), 0);
        chk("done_pulses", obs_done, exp_done ? 1 : 0);
        chk("err_pulses", obs_err, exp_done ? 0 : 1);
        chk("iter_cnt", obs_cnt, exp_cnt);
        chk("busy_cycles", obs_busy, exp_steps + 4 + obs_stalls);
        chk("flg_mod", obs_fmod, 32'(ms));
        chk("flg_mul", obs_fmul, 32'(md));
        chk("ab_en_pairing", obs_ab_bad, 0);
        chk("timeout", 32'(obs_timeout), 0);
`ifdef MOD_ARITH_SEQ_PERF_EN
        chk("perf_cyc", obs_perf, exp_steps + 4 + obs_stalls);
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.mod_sel = 1'b0; bus.abort = 1'b0;
        bus.dp_stall = 1'b0; bus.a_bin = 2'b00; bus.a_zero = 1'b0;

        tbl[0] = '{a0: 8,    mode: 1'b0, ms: 1'b1, steps: 3, cnt: 5, done: 1'b1};
        tbl[1] = '{a0: 0,    mode: 1'b1, ms: 1'b0, steps: 0, cnt: 0, done: 1'b1};
        tbl[2] = '{a0: 2,    mode: 1'b0, ms: 1'b0, steps: 2, cnt: 3, done: 1'b1};
        tbl[3] = '{a0: 6,    mode: 1'b1, ms: 1'b1, steps: 2, cnt: 3, done: 1'b1};
        tbl[4] = '{a0: 1024, mode: 1'b0, ms: 1'b0, steps: 4, cnt: 8, done: 1'b0};
        tbl[5] = '{a0: 3,    mode: 1'b1, ms: 1'b0, steps: 1, cnt: 2, done: 1'b1};
        tbl[6] = '{a0: 512,  mode: 1'b0, ms: 1'b1, steps: 4, cnt: 8, done: 1'b0};
        tbl[7] = '{a0: 10,   mode: 1'b1, ms: 1'b1, steps: 3, cnt: 5, done: 1'b1};

        // Reset held two cycles
        tick(); tick();
        chk("rst_u_op", 32'(bus.u_op), 3);
        chk("rst_u_en", 32'(bus.u_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_iter_cnt", 32'(bus.iter_cnt), 0);
        chk("rst_done_err", 32'({bus.done, bus.err}), 0);
        chk("rst_flags", 32'({bus.flg_mod, bus.flg_mul}), 0);
        rst = 1'b0;
        tick();

        // First command: exact op sequence and done on the 6th edge
        run_cmd(8, 1'b0, 1'b1, 0, 3);
        chk("t2_nops", obs_ops.size(), 5);
        if (obs_ops.size() == 5) begin
            chk("t2_op0", 32'(obs_ops[0]), 3);
            chk("t2_op1", 32'(obs_ops[1]), 0);
            chk("t2_op2", 32'(obs_ops[2]), 2);
            chk("t2_op3", 32'(obs_ops[3]), 1);
            chk("t2_op4", 32'(obs_ops[4]), 2);
        end
        chk("t2_done_edge", obs_end_edge, 6);
        chk("t2_cnt", obs_cnt, 5);
        chk("t2_flg_mod", obs_fmod, 1);

        // Table vectors, no stalls
        foreach (tbl[i]) begin
            model(tbl[i].a0);
            run_cmd(tbl[i].a0, tbl[i].mode, tbl[i].ms, 0, exp_steps);
            chk("tbl_steps", obs_ops.size(), tbl[i].steps + 2);
            chk("tbl_cnt", obs_cnt, tbl[i].cnt);
            chk("tbl_done", obs_done, tbl[i].done ? 1 : 0);
            chk("tbl_err", obs_err, tbl[i].done ? 0 : 1);
            chk("tbl_end_edge", obs_end_edge, tbl[i].steps + 3);
            check_cmd(tbl[i].ms, tbl[i].mode);
            tick();
        end

        // Stall for 3 cycles mid-ITER, budget then runs out
        bus.a_bin = 2'b00; bus.a_zero = 1'b0; bus.mode = 1'b1; bus.mod_sel = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        chk("st_first_step_en", 32'(bus.u_en), 1);
        chk("st_first_step_cnt", 32'(bus.iter_cnt), 2);
        bus.dp_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("st_stall_u_en", 32'({bus.u_en, bus.ab_en}), 0);
            chk("st_stall_cnt", 32'(bus.iter_cnt), 2);
            chk("st_stall_op", 32'(bus.u_op), 2);
        end
        bus.dp_stall = 1'b0;
        tick();
        chk("st_resume_en", 32'(bus.u_en), 1);
        chk("st_resume_cnt", 32'(bus.iter_cnt), 4);
        tick(); tick();
        chk("st_cnt_at_max", 32'(bus.iter_cnt), 8);
        tick();
        chk("st_err_pulse", 32'(bus.err), 1);
        chk("st_no_done", 32'(bus.done), 0);
        chk("st_err_busy", 32'(bus.busy), 1);
        tick();
        chk("st_idle_after_err", 32'({bus.busy, bus.err}), 0);

        // Abort in LOAD
        bus.a_zero = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("ab_in_load", 32'(bus.u_op), 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_idle", 32'({bus.busy, bus.u_en, bus.ab_en}), 0);
        chk("ab_no_pulse", 32'({bus.done, bus.err}), 0);
        tick(); tick(); tick();
        chk("ab_quiet", 32'({bus.busy, bus.done, bus.err}), 0);

        // start and abort together in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("sa_ignored", 32'({bus.busy, bus.u_en}), 0);
        tick();
        chk("sa_still_idle", 32'(bus.busy), 0);

        // start pulsed while busy is ignored (A already zero)
        bus.mode = 1'b0; bus.mod_sel = 1'b1; bus.start = 1'b1;
        tick();
        bus.mode = 1'b1; bus.mod_sel = 1'b0;
        tick(); tick();
        bus.start = 1'b0;
        tick();
        chk("sb_done", 32'(bus.done), 1);
        chk("sb_flags", 32'({bus.flg_mod, bus.flg_mul}), 2);
        tick();
        chk("sb_idle", 32'(bus.busy), 0);
`ifdef MOD_ARITH_SEQ_PERF_EN
        chk("sb_perf", 32'(bus.perf_cyc), 4);
`endif
        tick(); tick();
        chk("sb_no_requeue", 32'({bus.busy, bus.u_en, bus.done}), 0);

        // Reset mid-command
        bus.a_zero = 1'b0; bus.a_bin = 2'b00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("mr_u_op", 32'(bus.u_op), 3);
        chk("mr_quiet", 32'({bus.busy, bus.u_en, bus.ab_en, bus.done, bus.err}), 0);
        chk("mr_cnt", 32'(bus.iter_cnt), 0);
        chk("mr_flags", 32'({bus.flg_mod, bus.flg_mul}), 0);
        rst = 1'b0;
        tick();
        chk("mr_after", 32'({bus.busy, bus.done, bus.err}), 0);

        // Randomized commands with random stalls against the model
        for (int r = 0; r < 30; r++) begin
            int unsigned a0;
            bit md, ms;
            a0 = $urandom_range(2047);
            md = 1'($urandom);
            ms = 1'($urandom);
            model(a0);
            run_cmd(a0, md, ms, 30, exp_steps);
            check_cmd(ms, md);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
